// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a
// carry flop process one bit per clock, LSB first, behind valid/ready handshakes.
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             c, c_msb, op_r;

    logic             sum, cout;
    logic [WIDTH-1:0] res_next;

    // The single adder cell; B is pre-inverted and c preset to 1 for subtract.
    always_comb begin
        sum      = a_sh[0] ^ b_sh[0] ^ c;
        cout     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        res_next = {sum, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            c          <= 1'b0;
            c_msb      <= 1'b0;
            op_r       <= 1'b0;
            o_ready    <= 1'b0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_sh    <= i_a;
                        b_sh    <= i_b ^ {WIDTH{i_op}};
                        op_r    <= i_op;
                        c       <= i_op;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= RUN;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= cout;
                    cnt    <= cnt + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the sign bit.
                    if (cnt == CW'(WIDTH-2))
                        c_msb <= cout;
                    if (cnt == CW'(WIDTH-1)) begin
                        o_valid    <= 1'b1;
                        o_result   <= res_next;
                        o_carry    <= cout ^ op_r;
                        o_overflow <= c_msb ^ cout;
                        o_zero     <= (res_next == '0);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic         i_op = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_result;
    logic         o_carry, o_overflow, o_zero;

    int total = 0;
    int bad   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_carry(o_carry), .o_overflow(o_overflow), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One operation: wait for ready, accept, measure latency, optionally hold
    // the result under backpressure, check, then consume.
    task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er,
                         input logic ec, input logic ev, input logic ez,
                         input bit scramble, input int hold);
        int n;
        logic [W-1:0] held;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, ".rdy"}, o_ready, 1);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge i_clk); #1;
            if (o_valid) break;
            if (scramble) begin
                i_a = W'($urandom); i_b = W'($urandom); i_op = 1'($urandom);
                i_valid = 1'($urandom);
            end
        end
        i_valid = 1'b0;
        chk({tag, ".lat"}, n, W);
        held = o_result;
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                i_valid = 1'b1; i_op = 1'b1; i_a = 8'hAA; i_b = 8'h55;
            end
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            chk({tag, ".hv"}, o_valid, 1);
            chk({tag, ".hrdy"}, o_ready, 0);
            chk({tag, ".hres"}, o_result, held);
        end
        chk({tag, ".res"}, o_result, er);
        chk({tag, ".c"}, o_carry, ec);
        chk({tag, ".v"}, o_overflow, ev);
        chk({tag, ".z"}, o_zero, ez);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({tag, ".cons_v"}, o_valid, 0);
        chk({tag, ".cons_rdy"}, o_ready, 1);
        chk({tag, ".keep"}, o_result, er);
    endtask

    initial begin
        #12;
        chk("rst.rdy", o_ready, 0);
        chk("rst.v", o_valid, 0);
        chk("rst.res", o_result, 0);
        chk("rst.flags", {o_carry, o_overflow, o_zero}, 0);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst.rdy_rise", o_ready, 1);

        do_op("sub05_03", 1, 8'h05, 8'h03, 8'h02, 0, 0, 0, 0, 0);
        do_op("sub03_05", 1, 8'h03, 8'h05, 8'hFE, 1, 0, 0, 0, 0);
        do_op("sub80_01", 1, 8'h80, 8'h01, 8'h7F, 0, 1, 0, 0, 0);
        do_op("addFF_01", 0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 0);
        do_op("add7F_01", 0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 0);
        do_op("bp_add",   0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 5);
        do_op("post_bp",  1, 8'h40, 8'h41, 8'hFF, 1, 0, 0, 0, 0);
        do_op("scramble", 0, 8'hC8, 8'h64, 8'h2C, 1, 0, 0, 1, 0);

        // Abort mid-RUN with an asynchronous reset.
        @(negedge i_clk);
        i_op = 1'b1; i_a = 8'h5A; i_b = 8'h21; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort.v", o_valid, 0);
        chk("abort.rdy", o_ready, 0);
        chk("abort.res", o_result, 0);
        chk("abort.flags", {o_carry, o_overflow, o_zero}, 0);
        repeat (10) @(posedge i_clk);
        #1 chk("abort.no_v", o_valid, 0);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("abort.rdy_rise", o_ready, 1);
        do_op("sub10_10", 1, 8'h10, 8'h10, 8'h00, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
